// File: rtl/tlb_search_arb.sv
// tlb_search_arb
//   Arbitrates the single TLB search port between the instruction MMU (id 0),
//   the data MMU (id 1) and CP0 TLBP (id 2). Each lookup is accepted, searched
//   for one registered cycle, and then presented as a held response until it
//   is consumed.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   r_cp0_EntryHi               ASID [7:0]; VPN2 [31:13] used for TLBP
//   i_req_* / d_req_*           inst / data lookup request (valid, vaddr, ready)
//   p_req_valid / p_req_ready   TLBP request
//   flush                       cancels inst/data work, blocks new accepts
//   tlb_wr                      TLB written this cycle; the search is repeated
//   resp_valid / resp_ready     held response handshake
//   resp_id, resp_found ...     registered search results
//   s_vpn, s_odd, s_asid        search key to the TLB array
//   s_found ... s_v             combinational search results from the TLB

module tlb_search_arb #(
    parameter int TLBNUM = 16,
    localparam int IW = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   r_cp0_EntryHi,
    input  logic          i_req_valid,
    input  logic [31:0]   i_req_vaddr,
    output logic          i_req_ready,
    input  logic          d_req_valid,
    input  logic [31:0]   d_req_vaddr,
    output logic          d_req_ready,
    input  logic          p_req_valid,
    output logic          p_req_ready,
    input  logic          flush,
    input  logic          tlb_wr,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [1:0]    resp_id,
    output logic          resp_found,
    output logic [IW-1:0] resp_index,
    output logic [19:0]   resp_pfn,
    output logic [2:0]    resp_c,
    output logic          resp_d,
    output logic          resp_v,
    output logic [18:0]   s_vpn,
    output logic          s_odd,
    output logic [7:0]    s_asid,
    input  logic          s_found,
    input  logic [IW-1:0] s_index,
    input  logic [19:0]   s_pfn,
    input  logic [2:0]    s_c,
    input  logic          s_d,
    input  logic          s_v
);

    typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

    localparam logic [1:0] ID_INST = 2'd0;
    localparam logic [1:0] ID_DATA = 2'd1;
    localparam logic [1:0] ID_TLBP = 2'd2;

    state_t      state;
    logic        rr_ptr;       // 0: inst preferred, 1: data preferred
    logic [1:0]  lat_id;
    logic [18:0] lat_vpn;
    logic        lat_odd;
    logic [7:0]  lat_asid;

    logic        acc_ok;
    logic        grant_p;
    logic        grant_i;
    logic        grant_d;
    logic        accept;
    logic        drop;
    logic [31:0] sel_vaddr;
    logic        unused_bits;

    // A new request may enter when the port is idle or when the held
    // response is being consumed this cycle; never during flush or reset.
    assign acc_ok  = ((state == IDLE) || ((state == RESP) && resp_ready)) && !flush && !rst;

    // TLBP has absolute priority; inst/data share round-robin.
    assign grant_p = acc_ok && p_req_valid;
    assign grant_i = acc_ok && !p_req_valid && i_req_valid && (!d_req_valid || !rr_ptr);
    assign grant_d = acc_ok && !p_req_valid && d_req_valid && (!i_req_valid ||  rr_ptr);
    assign accept  = grant_p || grant_i || grant_d;

    assign p_req_ready = grant_p;
    assign i_req_ready = grant_i;
    assign d_req_ready = grant_d;

    assign sel_vaddr = grant_d ? d_req_vaddr : i_req_vaddr;

    // Flush only cancels MMU work; a TLBP probe always completes.
    assign drop = flush && (lat_id != ID_TLBP);

    // Search key is presented only while a transaction is in flight.
    assign s_vpn  = (state == IDLE) ? 19'd0 : lat_vpn;
    assign s_odd  = (state == IDLE) ? 1'b0  : lat_odd;
    assign s_asid = (state == IDLE) ? 8'd0  : lat_asid;

    assign resp_valid = (state == RESP);

    // Address page offset and EntryHi bits between VPN2 and ASID carry no
    // meaning for the search.
    assign unused_bits = &{1'b0, sel_vaddr[11:0], r_cp0_EntryHi[12:8]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= 1'b0;
            lat_id     <= 2'd0;
            lat_vpn    <= 19'd0;
            lat_odd    <= 1'b0;
            lat_asid   <= 8'd0;
            resp_id    <= 2'd0;
            resp_found <= 1'b0;
            resp_index <= '0;
            resp_pfn   <= 20'd0;
            resp_c     <= 3'd0;
            resp_d     <= 1'b0;
            resp_v     <= 1'b0;
        end else begin
            if (accept) begin
                // Pointer moves to the side that lost; TLBP leaves it alone.
                if (grant_i) begin
                    rr_ptr <= 1'b1;
                end else if (grant_d) begin
                    rr_ptr <= 1'b0;
                end
                lat_id   <= grant_p ? ID_TLBP : (grant_d ? ID_DATA : ID_INST);
                lat_vpn  <= grant_p ? r_cp0_EntryHi[31:13] : sel_vaddr[31:13];
                lat_odd  <= grant_p ? 1'b0 : sel_vaddr[12];
                lat_asid <= r_cp0_EntryHi[7:0];
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (drop) begin
                        state <= IDLE;
                    end else if (!tlb_wr) begin
                        // A concurrent write may make this cycle's result
                        // stale, so capture only on a write-free cycle.
                        resp_id    <= lat_id;
                        resp_found <= s_found;
                        resp_index <= s_index;
                        resp_pfn   <= s_pfn;
                        resp_c     <= s_c;
                        resp_d     <= s_d;
                        resp_v     <= s_v;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state <= accept ? LOOKUP : IDLE;
                    end else if (drop) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
